// File: rtl/l0_skew_feeder.sv
// West-edge feeder for the systolic MAC array: one FIFO lane per row, popped
// as a diagonal wavefront so lane k leaves k cycles after lane 0.
module l0_skew_feeder #(
   parameter int row   = 8,
   parameter int bw    = 4,
   parameter int depth = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [row*bw-1:0]   in,
   input  logic                wr,
   input  logic                rd,
   input  logic [1:0]          inst_in,
   output logic [row*bw-1:0]   out,
   output logic [row*2-1:0]    inst_out,
   output logic                full,
   output logic                ready,
   output logic                o_valid
);

   localparam int AW = $clog2(depth);
   typedef logic [AW:0] ptr_t;
   localparam ptr_t PTR_ONE = ptr_t'(1);

   // All lanes are written together, so one wide storage word per entry serves every lane.
   logic [row*bw-1:0]     mem_q [depth];
   ptr_t                  wr_ptr_q, wr_ptr_d;
   ptr_t                  rd_ptr_q [row];
   ptr_t                  rd_ptr_d [row];
   logic [row-2:0]        skew_req_q, skew_req_d;
   logic [(row-1)*2-1:0]  skew_inst_q, skew_inst_d;
   logic [row*bw-1:0]     out_q, out_d;
   logic [row*2-1:0]      inst_q, inst_d;
   logic [row-1:0]        valid_q, valid_d;

   logic [row-1:0]        req;
   logic [row*2-1:0]      inst_stage;
   logic [row-1:0]        lane_full;
   logic                  full_c;
   logic                  wr_en;
   logic                  pop;

   // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
   always_comb begin
      req         = {skew_req_q, rd};
      inst_stage  = {skew_inst_q, inst_in};
      skew_req_d  = req[row-2:0];
      skew_inst_d = inst_stage[(row-1)*2-1:0];
      out_d       = '0;
      inst_d      = '0;
      valid_d     = '0;
      lane_full   = '0;
      pop         = 1'b0;

      for (int k = 0; k < row; k++) begin
         lane_full[k] = (rd_ptr_q[k][AW-1:0] == wr_ptr_q[AW-1:0]) &&
                        (rd_ptr_q[k][AW] != wr_ptr_q[AW]);
      end
      full_c = |lane_full;
      wr_en  = wr && !full_c;

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;

      // Emptiness uses registered pointers only: a word written on this edge pops no earlier than the next.
      for (int k = 0; k < row; k++) begin
         pop         = req[k] && (rd_ptr_q[k] != wr_ptr_q);
         rd_ptr_d[k] = pop ? rd_ptr_q[k] + PTR_ONE : rd_ptr_q[k];
         if (pop) begin
            out_d[k*bw +: bw] = mem_q[rd_ptr_q[k][AW-1:0]][k*bw +: bw];
            inst_d[k*2 +: 2]  = inst_stage[k*2 +: 2];
            valid_d[k]        = 1'b1;
         end
      end
   end

   // NOTE: storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         skew_req_q  <= '0;
         skew_inst_q <= '0;
         out_q       <= '0;
         inst_q      <= '0;
         valid_q     <= '0;
         for (int k = 0; k < row; k++) begin
            rd_ptr_q[k] <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         skew_req_q  <= skew_req_d;
         skew_inst_q <= skew_inst_d;
         out_q       <= out_d;
         inst_q      <= inst_d;
         valid_q     <= valid_d;
         for (int k = 0; k < row; k++) begin
            rd_ptr_q[k] <= rd_ptr_d[k];
         end
      end
   end

   assign out      = out_q;
   assign inst_out = inst_q;
   assign o_valid  = |valid_q;
   assign full     = full_c;
   assign ready    = !full_c;

endmodule
